// File: rtl/inst_encoder.sv
// inst_encoder: packs RV32 instruction fields into 32-bit instruction words.
//
// Supports R/I/S/B/U/J formats and the LI pseudo-op. LI becomes a single ADDI,
// a single LUI, or LUI followed by ADDI. A two-state FSM emits the second
// word of that pair. There is one registered output stage. Valid/ready
// handshakes are used on both the input and the output side.
//
// Ports
//   _clk, _rst_n   clock and asynchronous active-low reset
//   _valid/ready_  input handshake; the field inputs are sampled on acceptance
//   _fmt           0=R 1=I 2=S 3=B 4=U 5=J 6=LI 7=reserved
//   _opcode, _funct3, _funct7, _rd, _rs1, _rs2, _imm   instruction fields
//   valid_/_ready  output handshake for inst_/err_
//   inst_          encoded instruction word
//   err_           range, alignment or format error for the word on inst_
//   count_         number of words taken downstream; wraps modulo 2^COUNT_W
module inst_encoder #(
  parameter int COUNT_W     = 32,
  parameter int CHECK_RANGE = 1
) (
  input  logic               _clk,
  input  logic               _rst_n,
  input  logic               _valid,
  output logic               ready_,
  input  logic [2:0]         _fmt,
  input  logic [6:0]         _opcode,
  input  logic [2:0]         _funct3,
  input  logic [6:0]         _funct7,
  input  logic [4:0]         _rd,
  input  logic [4:0]         _rs1,
  input  logic [4:0]         _rs2,
  input  logic [31:0]        _imm,
  output logic               valid_,
  input  logic               _ready,
  output logic [31:0]        inst_,
  output logic               err_,
  output logic [COUNT_W-1:0] count_
);

  typedef enum logic {IDLE, LI_LO} state_t;

  state_t state, state_nxt;

  function automatic logic in_range(input logic signed [31:0] v,
                                    input logic signed [31:0] lo,
                                    input logic signed [31:0] hi);
    return (v >= lo) && (v <= hi);
  endfunction

  logic signed [31:0] imm_s;
  logic [11:0]        lo_w;
  logic [19:0]        hi_w;
  logic [31:0]        word_w;
  logic               rng_err;
  logic               two_w;
  logic               accept;
  logic               take;

  logic [31:0]        inst_p1;
  logic               err_p1;
  logic               vld_p1;
  logic [COUNT_W-1:0] cnt_p1;
  logic [4:0]         li_rd_p1;
  logic [11:0]        li_lo_p1;

  assign imm_s = _imm;
  assign lo_w  = _imm[11:0];
  // Rounds for the sign of the low half. This equals (imm + 0x800) >> 12:
  // the carry into bit 12 is exactly imm[11].
  assign hi_w  = _imm[31:12] + {19'd0, _imm[11]};

  always_comb begin
    word_w  = 32'd0;
    rng_err = 1'b0;
    two_w   = 1'b0;
    case (_fmt)
      3'd0: word_w = {_funct7, _rs2, _rs1, _funct3, _rd, _opcode};
      3'd1: begin
        word_w  = {_imm[11:0], _rs1, _funct3, _rd, _opcode};
        rng_err = !in_range(imm_s, -32'sd2048, 32'sd2047);
      end
      3'd2: begin
        word_w  = {_imm[11:5], _rs2, _rs1, _funct3, _imm[4:0], _opcode};
        rng_err = !in_range(imm_s, -32'sd2048, 32'sd2047);
      end
      3'd3: begin
        word_w  = {_imm[12], _imm[10:5], _rs2, _rs1, _funct3, _imm[4:1], _imm[11], _opcode};
        rng_err = !in_range(imm_s, -32'sd4096, 32'sd4094) || _imm[0];
      end
      3'd4: begin
        word_w  = {_imm[31:12], _rd, _opcode};
        rng_err = (_imm[11:0] != 12'd0);
      end
      3'd5: begin
        word_w  = {_imm[20], _imm[10:1], _imm[11], _imm[19:12], _rd, _opcode};
        rng_err = !in_range(imm_s, -32'sd1048576, 32'sd1048574) || _imm[0];
      end
      3'd6: begin
        if (in_range(imm_s, -32'sd2048, 32'sd2047)) begin
          word_w = {lo_w, 5'd0, 3'b000, _rd, 7'h13};
        end else begin
          word_w = {hi_w, _rd, 7'h37};
          two_w  = (lo_w != 12'd0);
        end
      end
      default: begin
        word_w  = 32'd0;
        rng_err = 1'b1;
      end
    endcase
  end

  assign ready_ = (state == IDLE) && (!vld_p1 || _ready);
  assign accept = _valid && ready_;
  assign take   = vld_p1 && _ready;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept && two_w) state_nxt = LI_LO;
      LI_LO:   if (take) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge _clk or negedge _rst_n) begin
    if (!_rst_n) state <= IDLE;
    else         state <= state_nxt;
  end

  // ---- Output stage p1: the registered word, its error flag and the LI low-half latch ----
  always_ff @(posedge _clk or negedge _rst_n) begin
    if (!_rst_n) begin
      inst_p1  <= 32'd0;
      err_p1   <= 1'b0;
      vld_p1   <= 1'b0;
      cnt_p1   <= '0;
      li_rd_p1 <= 5'd0;
      li_lo_p1 <= 12'd0;
    end else begin
      if (accept) begin
        inst_p1 <= word_w;
        err_p1  <= (CHECK_RANGE != 0) && rng_err;
        vld_p1  <= 1'b1;
        if (two_w) begin
          li_rd_p1 <= _rd;
          li_lo_p1 <= lo_w;
        end
      end else if ((state == LI_LO) && take) begin
        // The LUI half is leaving this cycle, so replace it with the ADDI half.
        inst_p1 <= {li_lo_p1, li_rd_p1, 3'b000, li_rd_p1, 7'h13};
        err_p1  <= 1'b0;
        vld_p1  <= 1'b1;
      end else if (take) begin
        vld_p1 <= 1'b0;
      end
      if (take) cnt_p1 <= cnt_p1 + {{(COUNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign valid_ = vld_p1;
  assign inst_  = inst_p1;
  assign err_   = err_p1;
  assign count_ = cnt_p1;

endmodule

// File: tb/tb_inst_encoder.sv
module tb_inst_encoder;

  logic        _clk;
  logic        _rst_n;
  logic        _valid;
  logic        ready_;
  logic [2:0]  _fmt;
  logic [6:0]  _opcode;
  logic [2:0]  _funct3;
  logic [6:0]  _funct7;
  logic [4:0]  _rd;
  logic [4:0]  _rs1;
  logic [4:0]  _rs2;
  logic [31:0] _imm;
  logic        valid_;
  logic        _ready;
  logic [31:0] inst_;
  logic        err_;
  logic [31:0] count_;

  typedef struct packed {
    logic [31:0] inst;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int   exp_count = 0;

  inst_encoder #(.COUNT_W(32), .CHECK_RANGE(1)) dut (
    ._clk(_clk), ._rst_n(_rst_n), ._valid(_valid), .ready_(ready_),
    ._fmt(_fmt), ._opcode(_opcode), ._funct3(_funct3), ._funct7(_funct7),
    ._rd(_rd), ._rs1(_rs1), ._rs2(_rs2), ._imm(_imm),
    .valid_(valid_), ._ready(_ready), .inst_(inst_), .err_(err_), .count_(count_)
  );

  initial begin
    _clk = 1'b0;
    forever #5 _clk = ~_clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push(input logic [31:0] inst, input logic err);
    exp_t e;
    e.inst = inst;
    e.err  = err;
    sb.push_back(e);
  endtask

  // Issues one input transaction. It returns #1 after the accepting edge,
  // or after a bounded wait if the input is never accepted.
  task automatic send(input logic [2:0] fmt, input logic [6:0] op, input logic [2:0] f3,
                      input logic [6:0] f7, input logic [4:0] rd, input logic [4:0] rs1,
                      input logic [4:0] rs2, input logic [31:0] imm);
    int n;
    _fmt = fmt; _opcode = op; _funct3 = f3; _funct7 = f7;
    _rd = rd; _rs1 = rs1; _rs2 = rs2; _imm = imm;
    _valid = 1'b1;
    n = 0;
    @(negedge _clk);
    while (!ready_ && n < 50) begin
      @(negedge _clk);
      n++;
    end
    if (!ready_) begin
      chk("accept_timeout", 32'd0, 32'd1);
      _valid = 1'b0;
    end else begin
      @(posedge _clk);
      #1;
      _valid = 1'b0;
    end
  endtask

  // Monitor: compares each word that is taken downstream against the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge _clk);
      if (!_rst_n) begin
        exp_count = 0;
      end else if (valid_ && _ready) begin
        chk("count", count_, exp_count);
        if (sb.size() == 0) begin
          chk("unexpected_word", inst_, 32'hDEADBEEF);
        end else begin
          e = sb.pop_front();
          chk("inst", inst_, e.inst);
          chk("err", {31'd0, err_}, {31'd0, e.err});
        end
        exp_count++;
      end
    end
  end

  task automatic drain;
    int n;
    n = 0;
    while (sb.size() != 0 && n < 50) begin
      @(negedge _clk);
      n++;
    end
    chk("drain_empty", sb.size(), 0);
  endtask

  initial begin
    logic [31:0] c0;
    _rst_n = 1'b0; _valid = 1'b0; _ready = 1'b1;
    _fmt = 3'd0; _opcode = 7'd0; _funct3 = 3'd0; _funct7 = 7'd0;
    _rd = 5'd0; _rs1 = 5'd0; _rs2 = 5'd0; _imm = 32'd0;
    repeat (3) @(posedge _clk);
    #1;
    chk("rst_valid", {31'd0, valid_}, 32'd0);
    chk("rst_inst", inst_, 32'd0);
    chk("rst_err", {31'd0, err_}, 32'd0);
    chk("rst_count", count_, 32'd0);
    _rst_n = 1'b1;
    @(negedge _clk);
    chk("rst_ready", {31'd0, ready_}, 32'd1);
    @(posedge _clk);
    #1;

    // Format vectors, issued back-to-back to exercise full throughput
    push(32'h002081B3, 1'b0); send(3'd0, 7'h33, 3'd0, 7'd0, 5'd3, 5'd1, 5'd2, 32'd0);
    push(32'hFFF00093, 1'b0); send(3'd1, 7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'hFFFFFFFF);
    push(32'h80000093, 1'b1); send(3'd1, 7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd2048);
    push(32'hFE512E23, 1'b0); send(3'd2, 7'h23, 3'd2, 7'd0, 5'd0, 5'd2, 5'd5, 32'hFFFFFFFC);
    push(32'h00208463, 1'b0); send(3'd3, 7'h63, 3'd0, 7'd0, 5'd0, 5'd1, 5'd2, 32'd8);
    push(32'h00208163, 1'b1); send(3'd3, 7'h63, 3'd0, 7'd0, 5'd0, 5'd1, 5'd2, 32'd3);
    push(32'h12345137, 1'b0); send(3'd4, 7'h37, 3'd0, 7'd0, 5'd2, 5'd0, 5'd0, 32'h12345000);
    push(32'h12345137, 1'b1); send(3'd4, 7'h37, 3'd0, 7'd0, 5'd2, 5'd0, 5'd0, 32'h12345001);
    push(32'h001000EF, 1'b0); send(3'd5, 7'h6F, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd2048);
    push(32'h00000000, 1'b1); send(3'd7, 7'h33, 3'd1, 7'd1, 5'd1, 5'd1, 5'd1, 32'd1);

    // LI expansions
    push(32'h123452B7, 1'b0); push(32'h67828293, 1'b0);
    send(3'd6, 7'h00, 3'd0, 7'd0, 5'd5, 5'd0, 5'd0, 32'h12345678);
    @(negedge _clk);
    chk("li_lo_ready", {31'd0, ready_}, 32'd0);
    push(32'h123462B7, 1'b0); push(32'hFFF28293, 1'b0);
    send(3'd6, 7'h00, 3'd0, 7'd0, 5'd5, 5'd0, 5'd0, 32'h12345FFF);
    push(32'h7FF00293, 1'b0);
    send(3'd6, 7'h00, 3'd0, 7'd0, 5'd5, 5'd0, 5'd0, 32'h000007FF);
    push(32'h123452B7, 1'b0);
    send(3'd6, 7'h00, 3'd0, 7'd0, 5'd5, 5'd0, 5'd0, 32'h12345000);
    drain();

    // Backpressure in the middle of an LI pair
    @(posedge _clk);
    #1;
    _ready = 1'b0;
    c0 = count_;
    push(32'h123452B7, 1'b0); push(32'h67828293, 1'b0);
    send(3'd6, 7'h00, 3'd0, 7'd0, 5'd5, 5'd0, 5'd0, 32'h12345678);
    for (int i = 0; i < 3; i++) begin
      @(negedge _clk);
      chk("bp_inst", inst_, 32'h123452B7);
      chk("bp_ready", {31'd0, ready_}, 32'd0);
      chk("bp_count", count_, c0);
    end
    @(posedge _clk);
    #1;
    _ready = 1'b1;
    drain();

    // Reset while waiting to emit the ADDI half
    @(posedge _clk);
    #1;
    _ready = 1'b0;
    send(3'd6, 7'h00, 3'd0, 7'd0, 5'd5, 5'd0, 5'd0, 32'h12345678);
    @(negedge _clk);
    chk("pre_rst_ready", {31'd0, ready_}, 32'd0);
    #2;
    _rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", {31'd0, valid_}, 32'd0);
    chk("mid_rst_count", count_, 32'd0);
    @(posedge _clk);
    @(posedge _clk);
    #1;
    _rst_n = 1'b1;
    _ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge _clk);
      chk("post_rst_valid", {31'd0, valid_}, 32'd0);
      chk("post_rst_ready", {31'd0, ready_}, 32'd1);
    end
    @(posedge _clk);
    #1;
    push(32'h002081B3, 1'b0); send(3'd0, 7'h33, 3'd0, 7'd0, 5'd3, 5'd1, 5'd2, 32'd0);
    drain();
    @(negedge _clk);
    chk("final_count", count_, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
